// File: rtl/cond_flag_pkg.sv
// Shared types for the condition/flag unit: condition-code enum and NZCV bit positions.
package cond_flag_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  // Bit order matches the ALU Flags bus {N,Z,C,V}
  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Combinational ARM-style condition evaluator over a 4-bit NZCV value.
module cond_eval
  import cond_flag_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c & !z;
      LS: pass = !c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV holder with in-flight flag tracking and conditional-issue gating.
// Optional COND_FLAG_ERR_EN adds a sticky error output for counter underflow/overflow events.
module cond_flag_unit
  import cond_flag_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_wr_valid,
  input  logic [3:0]       flags_in,
  input  logic             issue_valid,
  input  logic [3:0]       issue_cond,
  input  logic             issue_setflags,
  output logic             issue_ready,
  output logic             exec_valid,
  output logic             exec_pass,
  output logic [3:0]       flags_out,
`ifdef COND_FLAG_ERR_EN
  output logic             err_sticky,
`endif
  output logic [CNT_W-1:0] pend_cnt
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);

  logic [3:0] nzcv;
  logic [3:0] eff;
  logic       pass;
  logic       dep_ok;
  logic       room_ok;
  logic       accept;
  logic       inc;
  logic       dec;

  // A flag write landing this cycle is visible to the instruction issuing alongside it
  assign eff = flag_wr_valid ? flags_in : nzcv;

  cond_eval u_cond_eval (
    .cond  (issue_cond),
    .flags (eff),
    .pass  (pass)
  );

  assign dep_ok = (cond_e'(issue_cond) == AL) || (cond_e'(issue_cond) == NV) ||
                  (pend_cnt == '0) || ((pend_cnt == CNT_W'(1)) && flag_wr_valid);
  assign room_ok = !issue_setflags || (pend_cnt < PEND_MAX) || flag_wr_valid;
  assign issue_ready = dep_ok && room_ok;

  assign accept = issue_valid && issue_ready;
  // A condition-failed op is squashed and never returns flags, so it is not counted
  assign inc = accept && issue_setflags && pass;
  assign dec = flag_wr_valid && (pend_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nzcv       <= 4'b0000;
      pend_cnt   <= '0;
      exec_valid <= 1'b0;
      exec_pass  <= 1'b0;
    end else begin
      if (flag_wr_valid) nzcv <= flags_in;
      exec_valid <= accept;
      if (accept) exec_pass <= pass;
      if (inc && !dec && (pend_cnt != PEND_MAX))
        pend_cnt <= pend_cnt + CNT_W'(1);
      else if (dec && !inc)
        pend_cnt <= pend_cnt - CNT_W'(1);
    end
  end

`ifdef COND_FLAG_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_sticky <= 1'b0;
    else if ((flag_wr_valid && (pend_cnt == '0)) || (inc && !dec && (pend_cnt == PEND_MAX)))
      err_sticky <= 1'b1;
  end
`endif

  assign flags_out = nzcv;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_cond_flag_unit;
  import cond_flag_pkg::*;

  localparam int MAX_PEND = 3;
  localparam int CNT_W    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flag_wr_valid;
  logic [3:0]       flags_in;
  logic             issue_valid;
  logic [3:0]       issue_cond;
  logic             issue_setflags;
  logic             issue_ready;
  logic             exec_valid;
  logic             exec_pass;
  logic [3:0]       flags_out;
  logic [CNT_W-1:0] pend_cnt;
`ifdef COND_FLAG_ERR_EN
  logic             err_sticky;
`endif

  always #5 clk = ~clk;

  cond_flag_unit #(.MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flag_wr_valid  (flag_wr_valid),
    .flags_in       (flags_in),
    .issue_valid    (issue_valid),
    .issue_cond     (issue_cond),
    .issue_setflags (issue_setflags),
    .issue_ready    (issue_ready),
    .exec_valid     (exec_valid),
    .exec_pass      (exec_pass),
    .flags_out      (flags_out),
`ifdef COND_FLAG_ERR_EN
    .err_sticky     (err_sticky),
`endif
    .pend_cnt       (pend_cnt)
  );

  int vec  = 0;
  int errs = 0;

  // Reference model state
  logic [3:0] m_nzcv;
  int         m_pend;
  logic       m_ev, m_ep, m_err;
  logic       rdy_obs, rdy_exp;

  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_ready(input logic [3:0] c, input logic sf, input logic fw);
    logic flags_known, has_room;
    flags_known = (c >= 4'd14) || (m_pend == 0) || (m_pend == 1 && fw);
    has_room    = !sf || (m_pend < MAX_PEND) || fw;
    return flags_known && has_room;
  endfunction

  // Drive one cycle, sample issue_ready mid-cycle, advance the model across the edge.
  task automatic cycle(input logic rn, input logic fw, input logic [3:0] fin,
                       input logic iv, input logic [3:0] c, input logic sf);
    logic [3:0] eff;
    logic acc, p, inc, dec;
    rst_n = rn; flag_wr_valid = fw; flags_in = fin;
    issue_valid = iv; issue_cond = c; issue_setflags = sf;
    @(negedge clk);
    rdy_obs = issue_ready;
    rdy_exp = ref_ready(c, sf, fw);
    @(posedge clk);
    eff = fw ? fin : m_nzcv;
    acc = iv && rdy_exp;
    p   = ref_pass(c, eff);
    if (!rn) begin
      m_nzcv = 4'b0; m_pend = 0; m_ev = 1'b0; m_ep = 1'b0; m_err = 1'b0;
    end else begin
      inc = acc && sf && p;
      dec = fw && (m_pend > 0);
      if (fw && m_pend == 0) m_err = 1'b1;
      if (inc && !dec && m_pend == MAX_PEND) m_err = 1'b1;
      m_pend = m_pend + int'(inc) - int'(dec);
      if (m_pend > MAX_PEND) m_pend = MAX_PEND;
      m_ev = acc;
      if (acc) m_ep = p;
      if (fw) m_nzcv = fin;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 4'hF, 1'b1, 4'hE, 1'b1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    vec++; if (flags_out !== 4'b0000) begin errs++; $display("FAIL reset_flags got=%h want=0", flags_out); end
    vec++; if (pend_cnt !== 2'd0) begin errs++; $display("FAIL reset_pend got=%0d want=0", pend_cnt); end
    vec++; if (exec_valid !== 1'b0) begin errs++; $display("FAIL reset_exec_valid got=%b want=0", exec_valid); end
    vec++; if (exec_pass !== 1'b0) begin errs++; $display("FAIL reset_exec_pass got=%b want=0", exec_pass); end
`ifdef COND_FLAG_ERR_EN
    vec++; if (err_sticky !== 1'b0) begin errs++; $display("FAIL reset_err got=%b want=0", err_sticky); end
`endif
  endtask

  task automatic test_basic_eq();
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0);
    vec++; if (rdy_obs !== 1'b1) begin errs++; $display("FAIL eq_ready got=%b want=1", rdy_obs); end
    vec++; if (exec_valid !== 1'b1 || exec_pass !== 1'b0) begin errs++;
      $display("FAIL eq_exec got=%b/%b want=1/0", exec_valid, exec_pass); end
    vec++; if (pend_cnt !== 2'd0) begin errs++; $display("FAIL eq_pend got=%0d want=0", pend_cnt); end
  endtask

  task automatic test_stall_bypass();
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
    vec++; if (pend_cnt !== 2'd1) begin errs++; $display("FAIL stall_pend1 got=%0d want=1", pend_cnt); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0);
      vec++; if (rdy_obs !== 1'b0 || exec_valid !== 1'b0) begin errs++;
        $display("FAIL stall_hold%0d ready=%b exec_valid=%b want 0/0", i, rdy_obs, exec_valid); end
    end
    cycle(1'b1, 1'b1, 4'b0100, 1'b1, 4'h1, 1'b0);
    vec++; if (rdy_obs !== 1'b1) begin errs++; $display("FAIL bypass_ready got=%b want=1", rdy_obs); end
    vec++; if (exec_valid !== 1'b1 || exec_pass !== 1'b0) begin errs++;
      $display("FAIL bypass_exec got=%b/%b want=1/0", exec_valid, exec_pass); end
    vec++; if (flags_out !== 4'b0100 || pend_cnt !== 2'd0) begin errs++;
      $display("FAIL bypass_state flags=%h pend=%0d want 4/0", flags_out, pend_cnt); end
  endtask

  task automatic test_cond_table();
    logic [3:0] conds [6];
    logic       exps  [6];
    logic [3:0] f;
    conds = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h8, 4'hF};
    exps  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    cycle(1'b1, 1'b1, 4'b1001, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b1, conds[i], 1'b0);
      vec++; if (exec_valid !== 1'b1 || exec_pass !== exps[i]) begin errs++;
        $display("FAIL table cond=%h valid=%b pass=%b want 1/%b", conds[i], exec_valid, exec_pass, exps[i]); end
    end
    // Sweep every code over random flags via bypass (counter idle so always ready)
    for (int c = 0; c < 16; c++) begin
      f = 4'($urandom_range(0, 15));
      cycle(1'b1, 1'b1, f, 1'b1, 4'(c), 1'b0);
      vec++; if (exec_pass !== m_ep || exec_valid !== 1'b1) begin errs++;
        $display("FAIL sweep cond=%h flags=%h pass=%b want %b", c, f, exec_pass, m_ep); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
    vec++; if (pend_cnt !== 2'd3) begin errs++; $display("FAIL sat_pend got=%0d want=3", pend_cnt); end
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
    vec++; if (rdy_obs !== 1'b0 || exec_valid !== 1'b0) begin errs++;
      $display("FAIL sat_full ready=%b valid=%b want 0/0", rdy_obs, exec_valid); end
    cycle(1'b1, 1'b1, 4'h3, 1'b1, 4'hE, 1'b1);
    vec++; if (rdy_obs !== 1'b1 || exec_valid !== 1'b1 || pend_cnt !== 2'd3) begin errs++;
      $display("FAIL sat_swap ready=%b valid=%b pend=%0d want 1/1/3", rdy_obs, exec_valid, pend_cnt); end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
    vec++; if (pend_cnt !== 2'd0) begin errs++; $display("FAIL sat_drain got=%0d want=0", pend_cnt); end
  endtask

  task automatic test_failed_setflags();
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    vec++; if (exec_valid !== 1'b1 || exec_pass !== 1'b0 || pend_cnt !== 2'd0) begin errs++;
      $display("FAIL failsf valid=%b pass=%b pend=%0d want 1/0/0", exec_valid, exec_pass, pend_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
    cycle(1'b1, 1'b1, 4'hA, 1'b1, 4'hE, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
    vec++; if (pend_cnt !== 2'd2) begin errs++; $display("FAIL midrst_pre got=%0d want=2", pend_cnt); end
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0);
    vec++; if (pend_cnt !== 2'd0 || flags_out !== 4'h0 || exec_valid !== 1'b0) begin errs++;
      $display("FAIL midrst pend=%0d flags=%h valid=%b want 0/0/0", pend_cnt, flags_out, exec_valid); end
`ifdef COND_FLAG_ERR_EN
    cycle(1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      vec++; if (err_sticky !== 1'b1) begin errs++; $display("FAIL err_set%0d got=%b want=1", i, err_sticky); end
    end
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    vec++; if (err_sticky !== 1'b0) begin errs++; $display("FAIL err_clear got=%b want=0", err_sticky); end
`endif
  endtask

  task automatic test_random();
    logic rn, fw, iv, sf;
    logic [3:0] fin, c;
    for (int i = 0; i < 600; i++) begin
      rn  = ($urandom_range(0, 63) != 0);
      fw  = ($urandom_range(0, 2) == 0);
      iv  = ($urandom_range(0, 2) != 0);
      sf  = $urandom_range(0, 1) == 1;
      fin = 4'($urandom_range(0, 15));
      c   = 4'($urandom_range(0, 15));
      cycle(rn, fw, fin, iv, c, sf);
      vec++;
      if (rdy_obs !== rdy_exp || exec_valid !== m_ev || exec_pass !== m_ep ||
          flags_out !== m_nzcv || pend_cnt !== m_pend[1:0]) begin
        errs++;
        $display("FAIL rand%0d rdy=%b/%b ev=%b/%b ep=%b/%b flags=%h/%h pend=%0d/%0d (got/want)",
                 i, rdy_obs, rdy_exp, exec_valid, m_ev, exec_pass, m_ep, flags_out, m_nzcv, pend_cnt, m_pend);
      end
`ifdef COND_FLAG_ERR_EN
      vec++; if (err_sticky !== m_err) begin errs++;
        $display("FAIL rand_err%0d got=%b want=%b", i, err_sticky, m_err); end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; flag_wr_valid = 1'b0; flags_in = 4'h0;
    issue_valid = 1'b0; issue_cond = 4'h0; issue_setflags = 1'b0;
    m_nzcv = 4'h0; m_pend = 0; m_ev = 1'b0; m_ep = 1'b0; m_err = 1'b0;
    test_reset();
    test_basic_eq();
    test_stall_bypass();
    test_cond_table();
    test_saturation();
    test_failed_setflags();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
